// File: rtl/multisim_pkg.sv
// -----------------------------------------------------------------------------
// multisim_pkg
// Shared helpers for the multisim pull-side upsizer and its output FIFO.
//   count_width(depth) : width of an occupancy counter that must hold 0..depth
//   idx_width(ratio)   : width of a lane index that must hold 0..ratio-1
//   entry_tag_t        : per-entry side information carried next to the packed
//                        data (only with MULTISIM_UPSIZER_FLUSH_EN defined)
// Optional feature macro: MULTISIM_UPSIZER_FLUSH_EN
// -----------------------------------------------------------------------------
package multisim_pkg;

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

`ifdef MULTISIM_UPSIZER_FLUSH_EN
    // Marks an entry produced by a flush (unfilled upper lanes are zero).
    typedef struct packed {
        logic partial;
    } entry_tag_t;
`endif

endpackage

// File: rtl/multisim_pull_upsizer_if.sv
// -----------------------------------------------------------------------------
// multisim_pull_upsizer_if
// Bundles the narrow input stream, the wide output stream and the FIFO
// occupancy of the upsizer.
//   master : the side that feeds words in and consumes packed words
//   slave  : the upsizer itself
// Signals: in_vld/in_data/in_rdy (narrow stream), out_vld/out_data/out_rdy
// (wide stream), count (FIFO occupancy), flush/out_partial (only with
// MULTISIM_UPSIZER_FLUSH_EN defined).
// -----------------------------------------------------------------------------
interface multisim_pull_upsizer_if #(
    parameter int unsigned IN_WIDTH = 64,
    parameter int unsigned RATIO    = 4,
    parameter int unsigned DEPTH    = 4
);
    import multisim_pkg::*;

    localparam int unsigned CNT_W = count_width(DEPTH);

    logic                      in_vld;
    logic [IN_WIDTH-1:0]       in_data;
    logic                      in_rdy;
    logic                      out_vld;
    logic [IN_WIDTH*RATIO-1:0] out_data;
    logic                      out_rdy;
    logic [CNT_W-1:0]          count;
`ifdef MULTISIM_UPSIZER_FLUSH_EN
    logic                      flush;
    logic                      out_partial;

    modport master (
        output in_vld, in_data, out_rdy, flush,
        input  in_rdy, out_vld, out_data, count, out_partial
    );
    modport slave (
        input  in_vld, in_data, out_rdy, flush,
        output in_rdy, out_vld, out_data, count, out_partial
    );
`else
    modport master (
        output in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_data, count
    );
    modport slave (
        input  in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_data, count
    );
`endif

endinterface

// File: rtl/multisim_fifo.sv
// -----------------------------------------------------------------------------
// multisim_fifo
// First-word-fall-through FIFO with occupancy count.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data (ignored when full)
//   push_data   : entry to write
//   pop         : drop the head entry (ignored when empty)
//   pop_data    : head entry, forced to zero while empty
//   full, empty : occupancy flags
//   count       : number of stored entries (0..DEPTH)
// Pointers wrap naturally; count alone tells full from empty.
// -----------------------------------------------------------------------------
module multisim_fifo
    import multisim_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign pop_data = empty ? '0 : mem[rd_ptr_reg];
    assign count    = count_reg;

endmodule

// File: rtl/multisim_pull_upsizer.sv
// -----------------------------------------------------------------------------
// multisim_pull_upsizer
// Packs RATIO consecutive IN_WIDTH-bit words (lane 0 at the LSBs) into one
// wide word and queues it in a small FWFT FIFO toward the DUT-side port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : multisim_pull_upsizer_if.slave (in_*, out_*, count and,
//                with the macro, flush/out_partial)
// Optional feature macro: MULTISIM_UPSIZER_FLUSH_EN adds flush (push the
// partially filled lane register, unfilled lanes zeroed) and out_partial.
// -----------------------------------------------------------------------------
module multisim_pull_upsizer
    import multisim_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 64,
    parameter int unsigned RATIO    = 4,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multisim_pull_upsizer_if.slave  bus
);
    localparam int unsigned OUT_W = IN_WIDTH * RATIO;
    localparam int unsigned IDX_W = idx_width(RATIO);
    localparam int unsigned CNT_W = count_width(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

`ifdef MULTISIM_UPSIZER_FLUSH_EN
    typedef struct packed {
        entry_tag_t        tag;
        logic [OUT_W-1:0]  data;
    } entry_t;
`else
    typedef struct packed {
        logic [OUT_W-1:0]  data;
    } entry_t;
`endif

    // Only lanes 0..RATIO-2 are stored; the last lane goes straight from
    // in_data into the FIFO on the completing edge.
    logic [RATIO-2:0][IN_WIDTH-1:0] lane_reg;
    logic [IDX_W-1:0]               idx_reg;
    logic [IDX_W-1:0]               idx_next;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             last_lane;
    logic             in_rdy_int;
    logic             in_hs;
    logic             push;
    logic [OUT_W-1:0] push_word;
    entry_t           push_entry;
    entry_t           head_entry;

    assign last_lane = (idx_reg == LAST_IDX);
    // Depends on registered state only, so there is no path from out_rdy.
    assign in_rdy_int = !last_lane || !fifo_full;
    assign in_hs      = bus.in_vld && in_rdy_int;

    for (genvar gi = 0; gi < RATIO - 1; gi++) begin : g_full_word
        assign push_word[gi*IN_WIDTH +: IN_WIDTH] = lane_reg[gi];
    end
    assign push_word[OUT_W-1 -: IN_WIDTH] = bus.in_data;

`ifdef MULTISIM_UPSIZER_FLUSH_EN
    logic             flush_go;
    logic [OUT_W-1:0] flush_word;

    // Lanes at or above idx hold stale data from an earlier word: zero them.
    for (genvar gi = 0; gi < RATIO - 1; gi++) begin : g_flush_word
        assign flush_word[gi*IN_WIDTH +: IN_WIDTH] =
            (idx_reg > IDX_W'(gi)) ? lane_reg[gi] : '0;
    end
    assign flush_word[OUT_W-1 -: IN_WIDTH] = '0;

    // An input handshake wins; the flush is retried while it stays asserted.
    assign flush_go = bus.flush && (idx_reg != '0) && !in_hs && !fifo_full;
    assign push     = (in_hs && last_lane) || flush_go;

    always_comb begin
        push_entry             = '0;
        push_entry.tag.partial = flush_go;
        push_entry.data        = flush_go ? flush_word : push_word;
    end

    assign bus.out_partial = head_entry.tag.partial;
`else
    assign push = in_hs && last_lane;

    always_comb begin
        push_entry      = '0;
        push_entry.data = push_word;
    end
`endif

    always_comb begin
        idx_next = idx_reg;
        if (in_hs) begin
            idx_next = last_lane ? '0 : idx_reg + 1'b1;
        end
`ifdef MULTISIM_UPSIZER_FLUSH_EN
        else if (flush_go) begin
            idx_next = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg  <= '0;
            lane_reg <= '0;
        end else begin
            idx_reg <= idx_next;
            for (int i = 0; i < RATIO - 1; i++) begin
                if (in_hs && (idx_reg == IDX_W'(i))) begin
                    lane_reg[i] <= bus.in_data;
                end
            end
        end
    end

    multisim_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (bus.out_rdy),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.in_rdy   = in_rdy_int;
    assign bus.out_vld  = !fifo_empty;
    assign bus.out_data = head_entry.data;
    assign bus.count    = fifo_count;

endmodule
